// File: rtl/stack_ctrl.sv
// LIFO stack controller in front of a 16x8 scratch RAM: turns push/pop requests
// into single-cycle RAM write/read bus cycles and tracks occupancy and errors.
module stack_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic [4:0] count,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       underflow,
    output logic [3:0] Address,
    output logic [7:0] ram_in,
    input  logic [7:0] ram_out,
    output logic       WE,
    output logic       CS
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t     state_r;
    logic [4:0] count_r;
    logic [7:0] dout_r;
    logic       dout_valid_r;
    logic       overflow_r;
    logic       underflow_r;
    logic [3:0] addr_r;
    logic [7:0] ram_in_r;
    logic       we_r;
    logic       cs_r;
    logic       empty_s;
    logic       full_s;

    // Occupancy flags decode straight from the count register.
    always_comb begin
        empty_s = (count_r == 5'd0);
        full_s  = (count_r == 5'd16);
    end

    // Bus-cycle FSM; the top entry sits at count-1, which is count[3:0]-1 mod 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            count_r      <= 5'd0;
            dout_r       <= 8'h00;
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
            addr_r       <= 4'd0;
            ram_in_r     <= 8'h00;
            we_r         <= 1'b0;
            cs_r         <= 1'b0;
        end else begin
            dout_valid_r <= 1'b0;
            // A violation on the same edge overrides this clear below.
            if (clr_err) begin
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
            end else begin
                overflow_r  <= overflow_r;
                underflow_r <= underflow_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (push) begin
                        if (!full_s) begin
                            addr_r   <= count_r[3:0];
                            ram_in_r <= din;
                            we_r     <= 1'b1;
                            cs_r     <= 1'b1;
                            state_r  <= ST_WRITE;
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end else if (pop) begin
                        if (!empty_s) begin
                            addr_r  <= count_r[3:0] - 4'd1;
                            we_r    <= 1'b0;
                            cs_r    <= 1'b1;
                            state_r <= ST_READ;
                        end else begin
                            underflow_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    count_r <= count_r + 5'd1;
                    we_r    <= 1'b0;
                    cs_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_READ: begin
                    dout_r       <= ram_out;
                    dout_valid_r <= 1'b1;
                    count_r      <= count_r - 5'd1;
                    cs_r         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    we_r    <= 1'b0;
                    cs_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = (state_r != ST_IDLE);
    assign count      = count_r;
    assign empty      = empty_s;
    assign full       = full_s;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;
    assign Address    = addr_r;
    assign ram_in     = ram_in_r;
    assign WE         = we_r;
    assign CS         = cs_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 16x8 RAM attached to its bus.
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       clr_err;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;
    logic [3:0] Address;
    logic [7:0] ram_in;
    logic [7:0] ram_out;
    logic       WE;
    logic       CS;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (CS && WE) mem[Address] <= ram_in;
    end
    assign ram_out = mem[Address];

    stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow), .Address(Address), .ram_in(ram_in),
        .ram_out(ram_out), .WE(WE), .CS(CS)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00; clr_err = 1'b0;
        #3;
        tests++;
        if ({Address, ram_in, WE, CS} !== {4'd0, 8'h00, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_bus got %h required %h", {Address, ram_in, WE, CS}, 14'h0);
        end
        tests++;
        if ({dout, dout_valid, busy, count} !== {8'h00, 1'b0, 1'b0, 5'd0}) begin
            fails++; $display("FAIL reset_data got %h required %h", {dout, dout_valid, busy, count}, 15'h0);
        end
        tests++;
        if ({empty, full, overflow, underflow} !== 4'b1000) begin
            fails++; $display("FAIL reset_flags got %b required 1000", {empty, full, overflow, underflow});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        push = 1'b1; din = 8'h0A;
        tick();
        push = 1'b0;
        tests++;
        if ({WE, CS, Address, busy, ram_in} !== {1'b1, 1'b1, 4'd0, 1'b1, 8'h0A}) begin
            fails++; $display("FAIL basic_write got %h required %h", {WE, CS, Address, busy, ram_in}, {1'b1, 1'b1, 4'd0, 1'b1, 8'h0A});
        end
        tick();
        tests++;
        if ({WE, CS, busy, count} !== {1'b0, 1'b0, 1'b0, 5'd1}) begin
            fails++; $display("FAIL basic_after_write got %h required %h", {WE, CS, busy, count}, {3'b000, 5'd1});
        end
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tests++;
        if ({CS, WE, Address, dout_valid} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL basic_read_cycle got %b required 1000000", {CS, WE, Address, dout_valid});
        end
        tick();
        tests++;
        if ({dout, dout_valid, count, empty} !== {8'h0A, 1'b1, 5'd0, 1'b1}) begin
            fails++; $display("FAIL basic_pop got %h required %h", {dout, dout_valid, count, empty}, {8'h0A, 1'b1, 5'd0, 1'b1});
        end
        tick();
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++; $display("FAIL basic_valid_pulse got %b required 0", dout_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; din = 8'(i);
            tick();
            push = 1'b0;
            tick();
        end
        tests++;
        if ({full, count} !== {1'b1, 5'd16}) begin
            fails++; $display("FAIL fill_full got %h required %h", {full, count}, {1'b1, 5'd16});
        end
        push = 1'b1; din = 8'hEE;
        tick();
        push = 1'b0;
        tests++;
        if ({WE, CS, busy, overflow, count} !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd16}) begin
            fails++; $display("FAIL fill_overflow got %h required %h", {WE, CS, busy, overflow, count}, {4'b0001, 5'd16});
        end
        tick();
        for (int i = 16; i >= 1; i--) begin
            pop = 1'b1;
            tick();
            pop = 1'b0;
            tick();
            tests++;
            if ({dout, dout_valid} !== {8'(i), 1'b1}) begin
                fails++; $display("FAIL fill_pop_order got %h required %h", {dout, dout_valid}, {8'(i), 1'b1});
            end
        end
        tests++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            fails++; $display("FAIL fill_drained got %h required %h", {count, empty}, {5'd0, 1'b1});
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++; $display("FAIL fill_clr_overflow got %b required 0", overflow);
        end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tests++;
        if ({underflow, CS, busy, dout, dout_valid} !== {1'b1, 1'b0, 1'b0, 8'h01, 1'b0}) begin
            fails++; $display("FAIL underflow_set got %h required %h", {underflow, CS, busy, dout, dout_valid}, {3'b100, 8'h01, 1'b0});
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++;
        if (underflow !== 1'b0) begin
            fails++; $display("FAIL underflow_clear got %b required 0", underflow);
        end
        pop = 1'b1; clr_err = 1'b1;
        tick();
        pop = 1'b0; clr_err = 1'b0;
        tests++;
        if (underflow !== 1'b1) begin
            fails++; $display("FAIL underflow_set_wins got %b required 1", underflow);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; din = 8'h31 + 8'(i);
            tick();
            push = 1'b0;
            tick();
        end
        push = 1'b1; pop = 1'b1; din = 8'h44;
        tick();
        push = 1'b0; pop = 1'b0;
        tests++;
        if ({WE, CS, Address, dout_valid} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin
            fails++; $display("FAIL pushpop_write got %b required %b", {WE, CS, Address, dout_valid}, {2'b11, 4'd3, 1'b0});
        end
        tick();
        tests++;
        if ({count, dout_valid} !== {5'd4, 1'b0}) begin
            fails++; $display("FAIL pushpop_count got %h required %h", {count, dout_valid}, {5'd4, 1'b0});
        end
    endtask

    task automatic test_reset_midwrite();
        push = 1'b1; din = 8'h77;
        tick();
        push = 1'b0;
        tests++;
        if ({WE, Address} !== {1'b1, 4'd4}) begin
            fails++; $display("FAIL midwrite_accept got %h required %h", {WE, Address}, {1'b1, 4'd4});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({WE, CS, count, busy} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
            fails++; $display("FAIL midwrite_async got %h required 0", {WE, CS, count, busy});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (mem[4] !== 8'h05) begin
            fails++; $display("FAIL midwrite_aborted got %h required 05", mem[4]);
        end
        push = 1'b1; din = 8'h99;
        tick();
        push = 1'b0;
        tests++;
        if ({WE, Address} !== {1'b1, 4'd0}) begin
            fails++; $display("FAIL midwrite_repush got %h required %h", {WE, Address}, {1'b1, 4'd0});
        end
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tick();
        tests++;
        if ({dout, dout_valid, count} !== {8'h99, 1'b1, 5'd0}) begin
            fails++; $display("FAIL midwrite_pop got %h required %h", {dout, dout_valid, count}, {8'h99, 1'b1, 5'd0});
        end
    endtask

    task automatic test_back_to_back();
        push = 1'b1; din = 8'h55;
        for (int k = 1; k <= 32; k++) begin
            tick();
            tests++;
            if ({WE, count} !== {1'(k % 2), 5'(k / 2)}) begin
                fails++; $display("FAIL b2b_cycle%0d got %h required %h", k, {WE, count}, {1'(k % 2), 5'(k / 2)});
            end
        end
        tick(); tick();
        push = 1'b0;
        tests++;
        if ({WE, count, full, overflow} !== {1'b0, 5'd16, 1'b1, 1'b1}) begin
            fails++; $display("FAIL b2b_saturate got %h required %h", {WE, count, full, overflow}, {1'b0, 5'd16, 2'b11});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_push_pop();
        test_reset_midwrite();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

LIFO stack controller sitting directly upstream of the 16x8 scratch RAM. It turns single-cycle push/pop requests from the datapath into RAM bus cycles on Address/ram_in/WE/CS, and returns popped bytes from the RAM's combinational read port. It tracks occupancy, reports full/empty, and flags overflow and underflow.

## Interface
Parameters: none. Depth is fixed at 16 entries of 8 bits, matching the RAM.

- clk  in  1  rising-edge clock, shared with the RAM
- rst_n  in  1  asynchronous active-low reset
- push  in  1  push request, sampled on a rising edge when busy=0
- pop  in  1  pop request, sampled on a rising edge when busy=0
- din  in  8  byte to push, sampled with push
- clr_err  in  1  synchronous clear of overflow/underflow
- dout  out  8  last popped byte, held until the next pop completes
- dout_valid  out  1  one-cycle pulse when dout is updated
- busy  out  1  high while a RAM cycle is in progress (state != IDLE)
- count  out  5  occupancy, 0..16
- empty  out  1  count==0
- full  out  1  count==16
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- Address  out  4  RAM address
- ram_in  out  8  RAM write data
- ram_out  in  8  RAM read data (combinational from the RAM)
- WE  out  1  RAM write enable
- CS  out  1  RAM chip select

## Operation
- States:
  - IDLE: CS=0, WE=0. The RAM output is tri-stated.
  - WRITE: one cycle, CS=1, WE=1.
  - READ: one cycle, CS=1, WE=0.
- All RAM-side outputs are registered.
- In IDLE at a rising edge:
  - push=1 and full=0: Address<=count[3:0], ram_in<=din, WE<=1, CS<=1, go to WRITE.
  - push=1 and full=1: no RAM access, overflow<=1, stay in IDLE.
  - pop=1 with push=0 and empty=0: Address<=count-1, CS<=1, WE<=0, go to READ.
  - pop=1 with push=0 and empty=1: no RAM access, underflow<=1, stay in IDLE.
  - push=1 and pop=1 together: pop is ignored, push proceeds under the rules above.
- WRITE at a rising edge: the RAM stores ram_in on this same edge. Then count<=count+1, WE<=0, CS<=0, go to IDLE.
- READ at a rising edge: dout<=ram_out, dout_valid<=1, count<=count-1, CS<=0, go to IDLE.
- dout_valid is forced to 0 on every edge except the READ completion edge.
- Requests arriving while busy=1 are dropped. They are not queued and do not set any flag.
- clr_err=1 clears both sticky flags. If clr_err and a new violation occur on the same edge, the set wins.
- Width rule: count is 5 bits and the address is count[3:0]. Because push is refused at count=16, count never exceeds 16 and never wraps.
- Reset: asynchronous. Every output goes to its reset value immediately, including mid-WRITE or mid-READ.
  - If WE is deasserted by reset before the WRITE edge, the RAM write is aborted.
  - RAM contents are not cleared.

## Timing
- Reset values:
  - Address=0, ram_in=0, WE=0, CS=0.
  - dout=0, dout_valid=0, busy=0, count=0.
  - empty=1, full=0, overflow=0, underflow=0.
- Push: accepted at edge E0. WE=CS=1 during E0..E1. RAM write and count+1 at E1. busy is high for exactly one cycle.
- Pop: accepted at edge E0. CS=1 during E0..E1, with Address=count-1. dout, dout_valid and count-1 update at E1. Latency is 1 cycle from acceptance to dout_valid.
- Maximum throughput is one operation per 2 cycles. A request held high through E1 is taken again at E2.
- empty and full are combinational from count, so they change on the edge after which count changes.

## Test plan
- After reset: push 0x0A, wait 2 cycles, then pop. Required: WE=1 and Address=0 in the write cycle; dout=0x0A with dout_valid pulsed once; count returns 0; empty=1.
- Push 0x01..0x10 (16 pushes). Required: full=1, count=16. A 17th push gives overflow=1, no WE pulse, count stays 16. Then 16 pops return 0x10 down to 0x01 in order.
- Pop from empty. Required: underflow=1, CS stays 0, dout unchanged. Then pulse clr_err: underflow returns 0.
- push=pop=1 together with count=3. Required: push occurs at Address=3, count becomes 4, no dout_valid.
- Assert rst_n=0 in the middle of the WRITE cycle, between the acceptance edge and the write edge. Required: WE and CS drop at once, count=0, busy=0. A later push at address 0 followed by a pop returns the new byte.
- Hold push high continuously with din=0x55 from count=0. Required: a write every 2nd cycle, and count increments by 1 per 2 cycles until it reaches 16.
